// File: rtl/board_scan_controller_if.sv
// board_scan_controller_if
// CPU data-memory side of the board scanner: the address/write bus from the
// CPU and the sensor read data and window-hit flag returned to the RAM/sensor
// read mux.
//   addr    : CPU data-memory address
//   wEn     : CPU data-memory write enable
//   dataIn  : CPU write data
//   dataOut : sensor read data (zero outside the sensor window)
//   hit     : addr falls inside the three-word sensor window
interface board_scan_controller_if;
    logic [31:0] addr;
    logic        wEn;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        hit;

    modport master (
        output addr, wEn, dataIn,
        input  dataOut, hit
    );

    modport slave (
        input  addr, wEn, dataIn,
        output dataOut, hit
    );
endinterface

// File: rtl/board_scan_controller.sv
// board_scan_controller
// Scans an 8x8 square-sensor matrix one row at a time, debounces whole
// frames and exposes the stable board plus a status word through a small
// memory-mapped window.
//   i_clock         : sole clock, rising edge
//   i_reset         : synchronous active-high reset
//   i_scan_en       : 1 = scan continuously, 0 = stop after current frame
//   o_row_n         : one-hot active-low row drive
//   i_col_n         : asynchronous active-low column returns (0 = piece)
//   o_board_changed : one-cycle pulse when the stable board updates
//   bus             : CPU window (BASE = rows 0-3, BASE+1 = rows 4-7,
//                     BASE+2 = {frame_count, 14'b0, scanning, changed_sticky})
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | rows released, waiting for i_scan_en
// S_DRIVE  | row r_row driven, waiting SETTLE_CYCLES for columns to settle
// S_SAMPLE | capture synchronized columns of r_row into r_raw
// S_COMMIT | rows released, debounce r_raw against the previous frame
module board_scan_controller #(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter logic [31:0] BASE_ADDR       = 32'd4096
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_scan_en,
    output logic [7:0]                    o_row_n,
    input  logic [7:0]                    i_col_n,
    output logic                          o_board_changed,
    board_scan_controller_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MATCH_NEEDED = 4'(DEBOUNCE_FRAMES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_settle_cnt;
    logic [2:0]  r_row;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [63:0] r_raw;
    logic [63:0] r_prev_raw;
    logic [63:0] r_stable;
    logic [3:0]  r_match_cnt;
    logic [15:0] r_frame_count;
    logic        r_changed_sticky;
    logic        r_board_changed;

    logic        w_scanning;
    logic [7:0]  w_sample;
    logic [3:0]  w_match_next;
    logic        w_commit_update;
    logic        w_sticky_clear;
    logic [31:0] w_offset;
    logic        w_unused_data_in;

    // Only bit 0 of a status write carries meaning.
    assign w_unused_data_in = ^bus.dataIn[31:1];

    assign w_sample = ~r_sync2;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_scan_en) w_next_state = S_DRIVE;
            S_DRIVE:  if (r_settle_cnt == SETTLE_LAST) w_next_state = S_SAMPLE;
            S_SAMPLE: w_next_state = (r_row == 3'd7) ? S_COMMIT : S_DRIVE;
            S_COMMIT: w_next_state = i_scan_en ? S_DRIVE : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_row_n    = 8'hFF;
        w_scanning = 1'b1;
        case (r_state)
            S_IDLE:            w_scanning = 1'b0;
            S_DRIVE, S_SAMPLE: o_row_n    = ~(8'd1 << r_row);
            default:           ;
        endcase
    end

    // ---------------- debounce ----------------
    always_comb begin
        w_match_next = 4'd0;
        if (r_raw == r_prev_raw) begin
            w_match_next = (r_match_cnt == 4'hF) ? 4'hF : r_match_cnt + 4'd1;
        end
    end

    assign w_commit_update = (r_state == S_COMMIT) && (w_match_next >= MATCH_NEEDED)
                             && (r_raw != r_stable);
    assign w_sticky_clear  = bus.wEn && (bus.addr == BASE_ADDR + 32'd2) && bus.dataIn[0];

    // ---------------- datapath ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1          <= 8'hFF;
            r_sync2          <= 8'hFF;
            r_settle_cnt     <= 8'd0;
            r_row            <= 3'd0;
            r_raw            <= 64'd0;
            r_prev_raw       <= 64'd0;
            r_stable         <= 64'd0;
            r_match_cnt      <= 4'd0;
            r_frame_count    <= 16'd0;
            r_changed_sticky <= 1'b0;
            r_board_changed  <= 1'b0;
        end else begin
            r_sync1         <= i_col_n;
            r_sync2         <= r_sync1;
            r_board_changed <= w_commit_update;

            // A commit setting the flag outranks a simultaneous CPU clear.
            if (w_commit_update) begin
                r_changed_sticky <= 1'b1;
            end else if (w_sticky_clear) begin
                r_changed_sticky <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_row        <= 3'd0;
                    r_settle_cnt <= 8'd0;
                end
                S_DRIVE: begin
                    r_settle_cnt <= r_settle_cnt + 8'd1;
                end
                S_SAMPLE: begin
                    r_raw[{r_row, 3'b000} +: 8] <= w_sample;
                    r_settle_cnt                <= 8'd0;
                    if (r_row != 3'd7) begin
                        r_row <= r_row + 3'd1;
                    end
                end
                S_COMMIT: begin
                    r_match_cnt   <= w_match_next;
                    r_prev_raw    <= r_raw;
                    r_frame_count <= r_frame_count + 16'd1;
                    r_row         <= 3'd0;
                    r_settle_cnt  <= 8'd0;
                    if (w_commit_update) begin
                        r_stable <= r_raw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_board_changed = r_board_changed;

    // ---------------- CPU read window ----------------
    // Offset arithmetic keeps the window decode a single compare.
    assign w_offset = bus.addr - BASE_ADDR;
    assign bus.hit  = (w_offset < 32'd3);

    always_comb begin
        case (w_offset)
            32'd0:   bus.dataOut = r_stable[31:0];
            32'd1:   bus.dataOut = r_stable[63:32];
            32'd2:   bus.dataOut = {r_frame_count, 14'b0, w_scanning, r_changed_sticky};
            default: bus.dataOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_board_scan_controller.sv
// Directed bench for board_scan_controller with SETTLE_CYCLES=2 and
// DEBOUNCE_FRAMES=2, giving 25-cycle frames. The sensor matrix is modelled
// as one optional piece on row 3, column 0.
module tb_board_scan_controller;

    localparam logic [31:0] BASE = 32'd4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic       piece = 1'b0;
    logic [7:0] row_n;
    logic [7:0] col_n;
    logic       bc;

    int n_total = 0;
    int n_bad   = 0;
    int n_pulses = 0;

    board_scan_controller_if bus();

    always #5 clk = ~clk;

    assign col_n = (piece && row_n == 8'hF7) ? 8'hFE : 8'hFF;

    board_scan_controller #(
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_FRAMES(2),
        .BASE_ADDR      (BASE)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_scan_en      (scan_en),
        .o_row_n        (row_n),
        .i_col_n        (col_n),
        .o_board_changed(bc),
        .bus            (bus)
    );

    always @(negedge clk) begin
        if (bc === 1'b1) n_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.dataOut, exp);
    endtask

    initial begin
        bus.addr   = BASE + 32'd2;
        bus.wEn    = 1'b0;
        bus.dataIn = 32'd0;

        // Reset, then idle with scan_en low
        ticks(3);
        rst = 1'b0;
        ticks(1);
        chk("rst_row_n", {24'd0, row_n}, 32'h0000_00FF);
        chk("rst_bc", {31'd0, bc}, 32'd0);
        rd("rst_status", BASE + 32'd2, 32'd0);
        chk("hit_base2", {31'd0, bus.hit}, 32'd1);
        rd("rst_base", BASE, 32'd0);
        ticks(1);
        rd("rst_base1", BASE + 32'd1, 32'd0);
        chk("hit_base1", {31'd0, bus.hit}, 32'd1);
        bus.addr = BASE - 32'd1;
        #1;
        chk("hit_below", {31'd0, bus.hit}, 32'd0);
        rd("rd_below", BASE + 32'd3, 32'd0);
        chk("hit_above", {31'd0, bus.hit}, 32'd0);
        for (int i = 0; i < 50; i++) begin
            ticks(1);
            chk("idle_row_n", {24'd0, row_n}, 32'h0000_00FF);
        end
        rd("idle_status", BASE + 32'd2, 32'd0);
        chk("idle_pulses", n_pulses, 32'd0);

        // Piece on row 3 col 0: two matching frames update the board
        piece   = 1'b1;
        scan_en = 1'b1;
        ticks(1);                                   // E0
        chk("f1_row0", {24'd0, row_n}, 32'h0000_00FE);
        ticks(9);                                   // E0+9
        chk("f1_row3", {24'd0, row_n}, 32'h0000_00F7);
        ticks(15);                                  // E0+24 commit 1
        chk("f1_commit_row_n", {24'd0, row_n}, 32'h0000_00FF);
        rd("f1_stable", BASE, 32'd0);
        ticks(1);                                   // E0+25
        rd("f1_status", BASE + 32'd2, 32'h0001_0002);
        chk("f1_pulses", n_pulses, 32'd0);
        ticks(24);                                  // E0+49 commit 2
        chk("f2_commit_row_n", {24'd0, row_n}, 32'h0000_00FF);
        ticks(1);                                   // E0+50
        chk("f2_bc", {31'd0, bc}, 32'd1);
        rd("f2_stable", BASE, 32'h0100_0000);
        rd("f2_status", BASE + 32'd2, 32'h0002_0003);
        ticks(1);                                   // E0+51
        chk("f2_bc_low", {31'd0, bc}, 32'd0);
        chk("f2_pulses", n_pulses, 32'd1);
        rd("f2_stable_hi", BASE + 32'd1, 32'd0);

        // Piece toggles each frame: never debounced
        for (int k = 3; k <= 6; k++) begin
            piece = (k % 2 == 0);
            ticks(25);                              // E0+25k+1
            rd("tog_status", BASE + 32'd2, {k[15:0], 14'd0, 2'b11});
            rd("tog_stable", BASE, 32'h0100_0000);
        end
        chk("tog_pulses", n_pulses, 32'd1);

        // Sticky clear, then clear colliding with a commit set
        piece      = 1'b0;
        bus.addr   = BASE + 32'd2;
        bus.dataIn = 32'd1;
        bus.wEn    = 1'b1;
        ticks(1);                                   // E0+152
        bus.wEn = 1'b0;
        rd("clr1_status", BASE + 32'd2, 32'h0006_0002);
        ticks(47);                                  // E0+199 commit 8
        chk("f8_commit_row_n", {24'd0, row_n}, 32'h0000_00FF);
        bus.wEn = 1'b1;
        ticks(1);                                   // E0+200
        bus.wEn = 1'b0;
        chk("f8_bc", {31'd0, bc}, 32'd1);
        rd("f8_status", BASE + 32'd2, 32'h0008_0003);
        rd("f8_stable", BASE, 32'd0);
        bus.addr = BASE + 32'd2;
        bus.wEn  = 1'b1;
        ticks(1);                                   // E0+201
        bus.wEn = 1'b0;
        rd("clr2_status", BASE + 32'd2, 32'h0008_0002);
        bus.addr   = BASE;
        bus.dataIn = 32'hFFFF_FFFF;
        bus.wEn    = 1'b1;
        ticks(1);                                   // E0+202
        bus.addr = BASE + 32'd1;
        ticks(1);                                   // E0+203
        bus.wEn    = 1'b0;
        bus.dataIn = 32'd0;
        rd("wr_ign_base", BASE, 32'd0);
        rd("wr_ign_base1", BASE + 32'd1, 32'd0);
        rd("wr_ign_status", BASE + 32'd2, 32'h0008_0002);

        // scan_en dropped during row 4 finishes the frame
        ticks(9);                                   // E0+212
        chk("stop_row4", {24'd0, row_n}, 32'h0000_00EF);
        scan_en = 1'b0;
        ticks(1);
        chk("stop_row4b", {24'd0, row_n}, 32'h0000_00EF);
        ticks(8);                                   // E0+221
        chk("stop_row7", {24'd0, row_n}, 32'h0000_007F);
        ticks(3);                                   // E0+224 commit 9
        chk("stop_commit_row_n", {24'd0, row_n}, 32'h0000_00FF);
        rd("stop_commit_status", BASE + 32'd2, 32'h0008_0002);
        ticks(1);                                   // E0+225 idle
        chk("stop_idle_row_n", {24'd0, row_n}, 32'h0000_00FF);
        rd("stop_idle_status", BASE + 32'd2, 32'h0009_0000);
        ticks(5);
        chk("stop_idle_row_n2", {24'd0, row_n}, 32'h0000_00FF);
        chk("stop_pulses", n_pulses, 32'd2);

        // Reset at row 6, then restart
        piece   = 1'b1;
        scan_en = 1'b1;
        ticks(1);                                   // F0
        chk("rs_row0", {24'd0, row_n}, 32'h0000_00FE);
        ticks(18);                                  // F0+18
        chk("rs_row6", {24'd0, row_n}, 32'h0000_00BF);
        rst = 1'b1;
        ticks(1);
        chk("rs_row_n", {24'd0, row_n}, 32'h0000_00FF);
        chk("rs_bc", {31'd0, bc}, 32'd0);
        rd("rs_status", BASE + 32'd2, 32'd0);
        rd("rs_stable", BASE, 32'd0);
        ticks(1);
        chk("rs_hold_row_n", {24'd0, row_n}, 32'h0000_00FF);
        piece = 1'b0;
        rst   = 1'b0;
        ticks(1);                                   // G0
        chk("re_row0", {24'd0, row_n}, 32'h0000_00FE);
        ticks(23);                                  // G0+23
        chk("re_row7", {24'd0, row_n}, 32'h0000_007F);
        ticks(1);                                   // G0+24 commit
        chk("re_commit_row_n", {24'd0, row_n}, 32'h0000_00FF);
        rd("re_commit_status", BASE + 32'd2, 32'h0000_0002);
        ticks(1);                                   // G0+25
        chk("re_next_row0", {24'd0, row_n}, 32'h0000_00FE);
        rd("re_status", BASE + 32'd2, 32'h0001_0002);
        chk("re_pulses", n_pulses, 32'd2);

        scan_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/board_scan_controller.md
BOARD_SCAN_CONTROLLER -- requirements
Module: board_scan_controller

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles a row is driven before its columns are sampled (legal 1..255).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 3: consecutive identical raw frames required before the stable board updates (legal 1..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'd4096: first word of the memory-mapped sensor window.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port scan_en  input  1  high = scan continuously; low = stop after current frame.
REQ-007 SHALL have port row_n  output  8  one-hot active-low row drive to the square-sensor matrix.
REQ-008 SHALL have port col_n  input  8  asynchronous active-low column returns; low = piece present.
REQ-009 SHALL have port addr  input  32  CPU data-memory address.
REQ-010 SHALL have port wEn  input  1  CPU data-memory write enable.
REQ-011 SHALL have port dataIn  input  32  CPU write data.
REQ-012 SHALL have port dataOut  output  32  sensor read data for the RAM/sensor mux.
REQ-013 SHALL have port hit  output  1  high when addr is within BASE_ADDR..BASE_ADDR+2.
REQ-014 SHALL have port board_changed  output  1  one-cycle pulse when the stable board updates.

Function
REQ-015 SHALL pass col_n through a 2-flop synchronizer; sampled values SHALL be the inverted synchronizer output (1 = occupied).
REQ-016 SHALL implement states IDLE, DRIVE, SAMPLE, COMMIT.
REQ-017 IDLE: row_n=8'hFF; if scan_en, next state DRIVE with row=0, settle counter=0.
REQ-018 DRIVE: row_n[row]=0, others 1; counter increments each cycle; after SETTLE_CYCLES cycles in DRIVE, next state SAMPLE.
REQ-019 SAMPLE (one cycle, row_n unchanged): raw[row*8+c] <= sample[c]; if row<7, row++ and go DRIVE; if row==7, go COMMIT.
REQ-020 COMMIT (one cycle, row_n=8'hFF): if raw==prev_raw, match_cnt saturating-increments (4 bits), else match_cnt=0; prev_raw<=raw; frame_count (16-bit) increments, wrapping 16'hFFFF->0.
REQ-021 In COMMIT, if the new match_cnt >= DEBOUNCE_FRAMES-1 and raw != stable, stable<=raw, board_changed=1 next cycle only, changed_sticky<=1.
REQ-022 After COMMIT, next state DRIVE (row 0) if scan_en, else IDLE; scan_en falling mid-frame SHALL NOT abort the frame.
REQ-023 Frame length SHALL be exactly 8*(SETTLE_CYCLES+1)+1 cycles from leaving IDLE/COMMIT to the next COMMIT.
REQ-024 dataOut SHALL be combinational: BASE_ADDR -> stable[31:0] (rows 0-3); BASE_ADDR+1 -> stable[63:32]; BASE_ADDR+2 -> {frame_count, 14'b0, scanning, changed_sticky}; otherwise 32'd0.
REQ-025 scanning SHALL be 1 whenever state != IDLE.
REQ-026 wEn=1 with addr==BASE_ADDR+2 and dataIn[0]=1 SHALL clear changed_sticky next cycle; a simultaneous set in COMMIT SHALL win (sticky stays 1).
REQ-027 Writes to BASE_ADDR and BASE_ADDR+1 SHALL be ignored.

Reset
REQ-028 Reset SHALL force state IDLE, row_n=8'hFF, row=0, counters=0, raw=prev_raw=stable=64'd0, match_cnt=0, frame_count=0, changed_sticky=0, board_changed=0, synchronizer flops=8'hFF.
REQ-029 Reset asserted mid-frame SHALL take effect at the next edge, discarding partial raw data; first DRIVE follows at the first edge after reset deasserts with scan_en=1.

Verification (SETTLE_CYCLES=2, DEBOUNCE_FRAMES=2)
REQ-030 Reset, scan_en=0 for 50 cycles -> row_n=8'hFF, dataOut at BASE+2 = 0, board_changed never high.
REQ-031 scan_en=1, col_n=8'hFE only while row 3 driven -> after 2nd COMMIT, stable bit 24 set, read BASE = 32'h0100_0000, one board_changed pulse, BASE+2 = 32'h0002_0003.
REQ-032 Piece toggles every frame -> match_cnt never reaches 1, stable unchanged, board_changed never pulses, frame_count keeps incrementing.
REQ-033 scan_en dropped during row 4 -> rows 5-7 still scanned, COMMIT occurs, then IDLE with row_n=8'hFF.
REQ-034 Write BASE+2 with dataIn=1 in the same cycle a COMMIT sets changed_sticky -> sticky reads 1; write again later -> reads 0.
REQ-035 Reset asserted at row 6 of a frame -> next cycle all outputs at reset values; restart yields first COMMIT exactly 25 cycles after leaving IDLE.
